leitor_rom: RTL and testbench

LEITOR_ROM -- requirements
Module: leitor_rom

---
 rtl/leitor_rom_pkg.sv | 19 +
 rtl/leitor_rom_soma.sv | 24 ++
 rtl/leitor_rom.sv | 108 ++++++++++
 tb/tb_leitor_rom.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leitor_rom_pkg.sv
// Shared definitions for the leitor_rom ROM reader: state encoding, widths
// and default terminator byte.
package leitor_rom_pkg;

   localparam int END_W  = 5;
   localparam int DADO_W = 8;
   localparam int CONT_W = 6;

   localparam logic [DADO_W-1:0] TERMINADOR_PADRAO = 8'h00;
   localparam logic [CONT_W-1:0] MAX_BYTES         = 6'd32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } estado_t;

endpackage

// File: rtl/leitor_rom_soma.sv
// Modulo-256 accumulator of the bytes accepted downstream; cleared when a
// new sequence starts.
module leitor_rom_soma
   import leitor_rom_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              limpa,
   input  logic              soma_en,
   input  logic [DADO_W-1:0] valor,
   output logic [DADO_W-1:0] soma
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         soma <= '0;
      end else if (limpa) begin
         soma <= '0;
      end else if (soma_en) begin
         soma <= soma + valor;
      end
   end

endmodule

// File: rtl/leitor_rom.sv
// leitor_rom: reads a combinational ROM from address 0 until TERMINADOR or
// ULTIMO_END, offering each byte with a valido/pronto handshake.
// Define LEITOR_ROM_CHECKSUM_EN to add the soma checksum output.
module leitor_rom
   import leitor_rom_pkg::*;
#(
   parameter logic [END_W-1:0]  ULTIMO_END = 5'd31,
   parameter logic [DADO_W-1:0] TERMINADOR = TERMINADOR_PADRAO
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [END_W-1:0]  endereco,
   input  logic [DADO_W-1:0] dado_rom,
   output logic [DADO_W-1:0] dado,
   output logic              valido,
   input  logic              pronto,
   output logic              ocupado,
   output logic              fim,
`ifdef LEITOR_ROM_CHECKSUM_EN
   output logic [DADO_W-1:0] soma,
`endif
   output logic [CONT_W-1:0] num_bytes
);

   estado_t estado, estado_nxt;
   logic    aceite;
   logic    inicio;

   function automatic logic [CONT_W-1:0] incr_sat(input logic [CONT_W-1:0] n);
      return (n >= MAX_BYTES) ? MAX_BYTES : n + CONT_W'(1);
   endfunction

   assign aceite  = (estado == SEND) && valido && pronto;
   assign inicio  = (estado == IDLE) && start;
   assign ocupado = (estado != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado <= IDLE;
      end else begin
         estado <= estado_nxt;
      end
   end

   always_comb begin
      estado_nxt = estado;
      case (estado)
         IDLE:  if (start) estado_nxt = FETCH;
         FETCH: estado_nxt = (dado_rom == TERMINADOR) ? DONE : SEND;
         SEND:  if (aceite) estado_nxt = (endereco == ULTIMO_END) ? DONE : FETCH;
         DONE:  estado_nxt = IDLE;
         default: estado_nxt = IDLE;
      endcase
   end

   // fim is registered from the next state so it is high exactly while in DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         endereco  <= '0;
         dado      <= '0;
         valido    <= 1'b0;
         fim       <= 1'b0;
         num_bytes <= '0;
      end else begin
         fim <= (estado_nxt == DONE);
         case (estado)
            IDLE: begin
               if (start) begin
                  endereco  <= '0;
                  num_bytes <= '0;
               end
            end
            FETCH: begin
               if (dado_rom != TERMINADOR) begin
                  dado   <= dado_rom;
                  valido <= 1'b1;
               end
            end
            SEND: begin
               if (aceite) begin
                  valido    <= 1'b0;
                  num_bytes <= incr_sat(num_bytes);
                  if (endereco != ULTIMO_END) begin
                     endereco <= endereco + END_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LEITOR_ROM_CHECKSUM_EN
   leitor_rom_soma u_soma (
      .clk     (clk),
      .reset   (reset),
      .limpa   (inicio),
      .soma_en (aceite),
      .valor   (dado),
      .soma    (soma)
   );
`else
   logic unused_inicio;
   assign unused_inicio = inicio;
`endif

endmodule

// File: tb/tb_leitor_rom.sv
// Directed testbench for leitor_rom; checks soma when LEITOR_ROM_CHECKSUM_EN
// is defined.
module tb_leitor_rom;

   logic       clk;
   logic       reset;
   logic       start;
   logic [4:0] endereco;
   logic [7:0] dado_rom;
   logic [7:0] dado;
   logic       valido;
   logic       pronto;
   logic       ocupado;
   logic       fim;
   logic [5:0] num_bytes;
`ifdef LEITOR_ROM_CHECKSUM_EN
   logic [7:0] soma;
`endif

   logic [7:0] rom [0:31];
   logic [7:0] exp_basic [0:9];
   logic [7:0] got [$];
   int         n_valido;
   int         checks;
   int         errors;

   assign dado_rom = rom[endereco];

   leitor_rom dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .endereco  (endereco),
      .dado_rom  (dado_rom),
      .dado      (dado),
      .valido    (valido),
      .pronto    (pronto),
      .ocupado   (ocupado),
      .fim       (fim),
`ifdef LEITOR_ROM_CHECKSUM_EN
      .soma      (soma),
`endif
      .num_bytes (num_bytes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // accepted-byte monitor: samples pre-edge values at each rising edge
   always @(posedge clk) begin
      if (valido && pronto) got.push_back(dado);
      if (valido) n_valido = n_valido + 1;
   end

   task automatic load_basic();
      for (int i = 0; i < 32; i++) rom[i] = (i < 10) ? exp_basic[i] : 8'h00;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_fim(input int limite, output int lat, output bit ok);
      ok  = 1'b0;
      lat = 0;
      for (int i = 1; i <= limite; i++) begin
         @(posedge clk); #1;
         if (fim) begin
            lat = i;
            ok  = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (endereco !== 5'd0) begin errors++; $display("FAIL reset_endereco got=%0d exp=0", endereco); end
      checks++; if (dado !== 8'h00) begin errors++; $display("FAIL reset_dado got=%h exp=00", dado); end
      checks++; if (valido !== 1'b0) begin errors++; $display("FAIL reset_valido got=%b exp=0", valido); end
      checks++; if (fim !== 1'b0) begin errors++; $display("FAIL reset_fim got=%b exp=0", fim); end
      checks++; if (num_bytes !== 6'd0) begin errors++; $display("FAIL reset_num_bytes got=%0d exp=0", num_bytes); end
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got=%b exp=0", ocupado); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat;
      bit ok;
      int base;
      load_basic();
      pronto = 1'b1;
      base = got.size();
      pulse_start();
      wait_fim(100, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_fim_timeout got=none exp=fim"); end
      checks++; if (lat != 21) begin errors++; $display("FAIL basic_latency got=%0d exp=21", lat); end
      checks++; if (got.size() - base != 10) begin errors++; $display("FAIL basic_count got=%0d exp=10", got.size() - base); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (base + i >= got.size() || got[base+i] !== exp_basic[i]) begin
            errors++;
            $display("FAIL basic_byte%0d got=%h exp=%h", i, (base + i < got.size()) ? got[base+i] : 8'hxx, exp_basic[i]);
         end
      end
      checks++; if (num_bytes !== 6'd10) begin errors++; $display("FAIL basic_num_bytes got=%0d exp=10", num_bytes); end
      checks++; if (endereco !== 5'd10) begin errors++; $display("FAIL basic_endereco got=%0d exp=10", endereco); end
      checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL basic_ocupado_done got=%b exp=1", ocupado); end
`ifdef LEITOR_ROM_CHECKSUM_EN
      checks++; if (soma !== 8'h78) begin errors++; $display("FAIL basic_soma got=%h exp=78", soma); end
`endif
      @(posedge clk); #1;
      checks++; if (fim !== 1'b0) begin errors++; $display("FAIL basic_fim_pulse got=%b exp=0", fim); end
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL basic_idle got=%b exp=0", ocupado); end
      checks++; if (num_bytes !== 6'd10) begin errors++; $display("FAIL basic_num_hold got=%0d exp=10", num_bytes); end
   endtask

   task automatic test_stall();
      int lat;
      bit ok;
      int base;
      bit achou;
      load_basic();
      pronto = 1'b1;
      base = got.size();
      pulse_start();
      achou = 1'b0;
      for (int i = 0; i < 40 && !achou; i++) begin
         if (valido && dado == 8'h48) achou = 1'b1;
         else begin @(posedge clk); #1; end
      end
      checks++; if (!achou) begin errors++; $display("FAIL stall_find got=none exp=48"); end
      pronto = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if (dado !== 8'h48 || valido !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold%0d got=%h/%b exp=48/1", c, dado, valido);
         end
      end
      pronto = 1'b1;
      wait_fim(100, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_fim_timeout got=none exp=fim"); end
      checks++; if (got.size() - base != 10) begin errors++; $display("FAIL stall_count got=%0d exp=10", got.size() - base); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (base + i >= got.size() || got[base+i] !== exp_basic[i]) begin
            errors++;
            $display("FAIL stall_byte%0d got=%h exp=%h", i, (base + i < got.size()) ? got[base+i] : 8'hxx, exp_basic[i]);
         end
      end
      checks++; if (num_bytes !== 6'd10) begin errors++; $display("FAIL stall_num_bytes got=%0d exp=10", num_bytes); end
      @(posedge clk); #1;
   endtask

   task automatic test_full();
      int lat;
      bit ok;
      int base;
      for (int i = 0; i < 32; i++) rom[i] = 8'hFF;
      pronto = 1'b1;
      base = got.size();
      pulse_start();
      wait_fim(200, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_fim_timeout got=none exp=fim"); end
      checks++; if (lat != 64) begin errors++; $display("FAIL full_latency got=%0d exp=64", lat); end
      checks++; if (got.size() - base != 32) begin errors++; $display("FAIL full_count got=%0d exp=32", got.size() - base); end
      checks++; if (endereco !== 5'd31) begin errors++; $display("FAIL full_endereco got=%0d exp=31", endereco); end
      checks++; if (num_bytes !== 6'd32) begin errors++; $display("FAIL full_num_bytes got=%0d exp=32", num_bytes); end
`ifdef LEITOR_ROM_CHECKSUM_EN
      checks++; if (soma !== 8'hE0) begin errors++; $display("FAIL full_soma got=%h exp=e0", soma); end
`endif
      @(posedge clk); #1;
      checks++; if (valido !== 1'b0 || ocupado !== 1'b0) begin errors++; $display("FAIL full_no_wrap got=%b/%b exp=0/0", valido, ocupado); end
      checks++; if (endereco !== 5'd31) begin errors++; $display("FAIL full_endereco_hold got=%0d exp=31", endereco); end
   endtask

   task automatic test_empty();
      int lat;
      bit ok;
      int base;
      int nv;
      for (int i = 0; i < 32; i++) rom[i] = 8'h00;
      pronto = 1'b1;
      base = got.size();
      nv = n_valido;
      pulse_start();
      wait_fim(20, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL empty_fim_timeout got=none exp=fim"); end
      checks++; if (lat != 1) begin errors++; $display("FAIL empty_latency got=%0d exp=1", lat); end
      checks++; if (n_valido != nv) begin errors++; $display("FAIL empty_valido got=%0d exp=0", n_valido - nv); end
      checks++; if (got.size() != base) begin errors++; $display("FAIL empty_count got=%0d exp=0", got.size() - base); end
      checks++; if (num_bytes !== 6'd0) begin errors++; $display("FAIL empty_num_bytes got=%0d exp=0", num_bytes); end
`ifdef LEITOR_ROM_CHECKSUM_EN
      checks++; if (soma !== 8'h00) begin errors++; $display("FAIL empty_soma got=%h exp=00", soma); end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int lat;
      bit ok;
      int base;
      bit achou;
      load_basic();
      pronto = 1'b1;
      pulse_start();
      achou = 1'b0;
      for (int i = 0; i < 40 && !achou; i++) begin
         if (valido && endereco == 5'd2) achou = 1'b1;
         else begin @(posedge clk); #1; end
      end
      checks++; if (!achou) begin errors++; $display("FAIL rstmid_find got=none exp=addr2"); end
      pronto = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++; if (valido !== 1'b0) begin errors++; $display("FAIL rstmid_valido got=%b exp=0", valido); end
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL rstmid_ocupado got=%b exp=0", ocupado); end
      checks++; if (endereco !== 5'd0 || num_bytes !== 6'd0) begin errors++; $display("FAIL rstmid_regs got=%0d/%0d exp=0/0", endereco, num_bytes); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      pronto = 1'b1;
      base = got.size();
      pulse_start();
      checks++; if (endereco !== 5'd0 || ocupado !== 1'b1) begin errors++; $display("FAIL rstmid_restart got=%0d/%b exp=0/1", endereco, ocupado); end
      wait_fim(100, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_fim_timeout got=none exp=fim"); end
      checks++; if (got.size() - base != 10) begin errors++; $display("FAIL rstmid_count got=%0d exp=10", got.size() - base); end
      checks++; if (base >= got.size() || got[base] !== 8'h13) begin errors++; $display("FAIL rstmid_first got=%h exp=13", (base < got.size()) ? got[base] : 8'hxx); end
      @(posedge clk); #1;
   endtask

   task automatic test_start_ignored();
      int lat;
      bit ok;
      int base;
      bit achou;
      load_basic();
      pronto = 1'b1;
      base = got.size();
      pulse_start();
      achou = 1'b0;
      for (int i = 0; i < 40 && !achou; i++) begin
         if (valido && got.size() - base == 3) achou = 1'b1;
         else begin @(posedge clk); #1; end
      end
      checks++; if (!achou) begin errors++; $display("FAIL ign_find got=none exp=send"); end
      pulse_start();
      wait_fim(100, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ign_fim_timeout got=none exp=fim"); end
      pulse_start();
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL ign_done_start got=%b exp=0", ocupado); end
      @(posedge clk); #1;
      checks++; if (ocupado !== 1'b0 || fim !== 1'b0) begin errors++; $display("FAIL ign_idle got=%b/%b exp=0/0", ocupado, fim); end
      checks++; if (got.size() - base != 10) begin errors++; $display("FAIL ign_count got=%0d exp=10", got.size() - base); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (base + i >= got.size() || got[base+i] !== exp_basic[i]) begin
            errors++;
            $display("FAIL ign_byte%0d got=%h exp=%h", i, (base + i < got.size()) ? got[base+i] : 8'hxx, exp_basic[i]);
         end
      end
      checks++; if (num_bytes !== 6'd10) begin errors++; $display("FAIL ign_num_bytes got=%0d exp=10", num_bytes); end
`ifdef LEITOR_ROM_CHECKSUM_EN
      checks++; if (soma !== 8'h78) begin errors++; $display("FAIL ign_soma got=%h exp=78", soma); end
`endif
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      n_valido = 0;
      reset    = 1'b1;
      start    = 1'b0;
      pronto   = 1'b0;
      exp_basic = '{8'h13, 8'h15, 8'h16, 8'h04, 8'h48, 8'h04, 8'h02, 8'h0C, 8'h37, 8'hA5};
      for (int i = 0; i < 32; i++) rom[i] = 8'h00;
      test_reset();
      test_basic();
      test_stall();
      test_full();
      test_empty();
      test_reset_mid();
      test_start_ignored();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
